// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. A single 4-bit carry-lookahead
//   slice is reused once per clock, LSB nibble first, with the inter-nibble
//   carry held in a register. Handshakes on both sides are valid/ready.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start_valid/ready upstream handshake; ready only while idle
//   a, b, cin, sub    operands and mode, captured at accept
//   result_valid/ready downstream handshake
//   sum, cout         result and carry (in subtract, cout=0 means borrow)
//   overflow, zero    two's-complement overflow, sum==0
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead slice: all carries computed from generate/propagate.
module CLA_adder4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Operands viewed as nibble arrays so the slice input is a plain index.
    logic [N-1:0][3:0]     r_a;
    logic [N-1:0][3:0]     r_b;
    logic [N-1:0][3:0]     r_acc;      // working sum, filled nibble by nibble
    logic [N-1:0][3:0]     w_acc_next;
    logic                  r_carry;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [IDX_W-1:0]      r_idx;

    logic [WIDTH-1:0]      r_sum;
    logic                  r_cout;
    logic                  r_ovf;
    logic                  r_zero;
    logic                  r_result_valid;

    logic                  w_accept;
    logic                  w_last;
    logic [WIDTH-1:0]      w_b_in;
    logic [3:0]            w_sl_sum;
    logic                  w_sl_cout;

    assign start_ready  = (r_state == S_IDLE);
    assign result_valid = r_result_valid;
    assign sum          = r_sum;
    assign cout         = r_cout;
    assign overflow     = r_ovf;
    assign zero         = r_zero;

    assign w_accept = start_valid & start_ready;
    assign w_last   = (r_idx == IDX_W'(N - 1));
    // Subtract is A + ~B + ~borrow_in.
    assign w_b_in   = sub ? ~b : b;

    CLA_adder4bit u_slice (
        .i_a    (r_a[r_idx]),
        .i_b    (r_b[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_sl_sum),
        .o_cout (w_sl_cout)
    );

    // Full sum including the nibble being produced this cycle; on the last
    // nibble this is the final result used for the zero flag.
    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_idx] = w_sl_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_state_next = S_RUN;
            S_RUN:   if (w_last)       w_state_next = S_DONE;
            S_DONE:  if (result_ready) w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_carry        <= 1'b0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_idx          <= '0;
            r_sum          <= '0;
            r_cout         <= 1'b0;
            r_ovf          <= 1'b0;
            r_zero         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= w_b_in;
                        r_carry  <= cin ^ sub;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= w_b_in[WIDTH-1];
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_sl_cout;
                    if (w_last) begin
                        // Outputs only change here, so they stay stable
                        // through the following RUN of the next operation.
                        r_idx  <= '0;
                        r_sum  <= w_acc_next;
                        r_cout <= w_sl_cout;
                        r_ovf  <= (r_sign_a == r_sign_b) & (w_sl_sum[3] != r_sign_a);
                        r_zero <= (w_acc_next == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .sub          (sub),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .cout         (cout),
        .overflow     (overflow),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic done with plain integers.
    task automatic ref_calc(input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic tc, input logic ts,
                            output logic [15:0] rs, output logic rc,
                            output logic ro, output logic rz);
        int ua, ub, sa, sb, full, sres;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        if (!ts) begin
            full = ua + ub + int'(tc);
            sres = sa + sb + int'(tc);
            rc   = (full >= 65536);
        end else begin
            full = ua - ub - int'(tc);
            sres = sa - sb - int'(tc);
            rc   = (full >= 0);
        end
        rs = full[15:0];
        ro = (sres > 32767) || (sres < -32768);
        rz = (rs == 16'h0);
    endtask

    // Model: phase 0 idle, 1 computing (counts down N edges), 2 result held.
    int          m_phase;
    int          m_left;
    logic [15:0] m_sum, p_sum;
    logic        m_cout, m_ovf, m_zero, m_valid;
    logic        p_cout, p_ovf, p_zero;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_left <= 0; m_valid <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                    logic [15:0] s; logic c, o, z;
                    ref_calc(a, b, cin, sub, s, c, o, z);
                    p_sum <= s; p_cout <= c; p_ovf <= o; p_zero <= z;
                    m_left  <= N;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2; m_valid <= 1'b1;
                        m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf; m_zero <= p_zero;
                    end
                end
                default: if (result_ready) begin
                    m_phase <= 0; m_valid <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("start_ready", start_ready, (m_phase == 0));
        chk("result_valid", result_valid, m_valid);
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("overflow", overflow, m_ovf);
        chk("zero", zero, m_zero);
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input logic ez, input int hold);
        int k;
        a = ta; b = tb_v; cin = tc; sub = ts; start_valid = 1'b1; result_ready = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        k = 0;
        while (!result_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("timeout", 32'd0, 32'd1);
        chk("latency", k, N);
        chk("lit_sum", sum, es);
        chk("lit_cout", cout, ec);
        chk("lit_ovf", overflow, eo);
        chk("lit_zero", zero, ez);
        chk("model_pin_sum", m_sum, es);
        chk("model_pin_flags", {m_cout, m_ovf, m_zero}, {ec, eo, ez});
        repeat (hold) begin
            start_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk("bp_sum", sum, es);
            chk("bp_ready", start_ready, 1'b0);
            chk("bp_valid", result_valid, 1'b1);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("release_valid", result_valid, 1'b0);
        chk("release_ready", start_ready, 1'b1);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_sum", sum, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 5);

        // Abort two cycles into RUN; start_valid is held high with rst.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_valid = 1'b0;
        chk("abort_ready", start_ready, 1'b1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", result_valid, 1'b0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        // Random traffic with random backpressure and rare resets.
        repeat (1500) begin
            start_valid  = 1'($urandom);
            a            = pick_operand();
            b            = pick_operand();
            cin          = 1'($urandom);
            sub          = 1'($urandom);
            result_ready = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start_valid = 1'b0; result_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor for the ALU. Uses a single 4-bit carry-lookahead slice (instance of CLA_adder4bit) once per clock, one nibble per cycle from LSB to MSB, with the carry held in a register between cycles.
- Trades latency for area on wide datapaths. Sits between the operand-select stage (upstream, valid/ready) and the ALU result/flag register (downstream, valid/ready).

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  upstream presents an operation.
- start_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A, sampled only at accept.
- b  input  WIDTH  operand B, sampled only at accept.
- cin  input  1  carry-in for add; borrow-in for subtract. Sampled at accept.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin. Sampled at accept.
- result_valid  output  1  result is held on the outputs.
- result_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; in subtract mode 0 means borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- N = WIDTH/4. Nibble index counter is max(1, clog2(N)) bits wide.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; idx = 0; carry register = 0.
  - sum, cout, overflow, zero = 0; result_valid = 0; start_ready = 1.
- Outputs:
  - result_valid is a registered state decode.
  - start_ready is a combinational decode of state == IDLE. No combinational path from any input to any output.
- IDLE:
  - Accept when start_valid & start_ready.
  - On accept, register:
    - a_r = a
    - b_r = sub ? ~b : b
    - carry = cin ^ sub
    - sign_a = a[WIDTH-1], sign_b = b_r[WIDTH-1]
    - idx = 0
  - Go to RUN.
- RUN, each cycle:
  - The slice adds a_r[4*idx+:4] + b_r[4*idx+:4] + carry.
  - sum nibble idx gets the slice sum; carry gets the slice Cout; idx increments.
  - When idx == N-1, go to DONE in the same edge.
  - Operands sampled at accept are frozen; input changes during RUN are ignored.
- Entering DONE (same edge as the last nibble):
  - cout = final slice Cout.
  - overflow = (sign_a == sign_b) & (sum[WIDTH-1] != sign_a), using the final MSB nibble.
  - zero = (full sum == 0), using the final MSB nibble.
  - result_valid = 1.
- Latency:
  - Accept on edge 0; result_valid is high after edge N (4 edges for WIDTH=16).
  - Minimum initiation interval is N+2 cycles. No overlap: DONE → IDLE → accept.
- DONE:
  - sum, cout, overflow and zero are held stable while result_valid & !result_ready.
  - On result_valid & result_ready, go to IDLE and clear result_valid.
  - sum and flags keep their values until the next DONE.
  - start_valid is ignored in DONE.
- Boundary cases:
  - WIDTH=4: a single RUN cycle.
  - Carry propagates across every nibble boundary (e.g. 0xFFFF+1).
  - Subtract wrap: 0-1 = all ones, cout = 0.
  - rst asserted in RUN or DONE aborts the operation with no result_valid pulse. start_ready = 1 in the first cycle after rst deasserts.
  - Simultaneous start_valid and rst: rst wins, nothing is accepted.

Test Plan:
- WIDTH=16, add 0x1234 + 0x4321, cin=0 → after 4 cycles result_valid=1, sum=0x5555, cout=0, overflow=0, zero=0.
- Add 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, zero=1, overflow=0; checks carry ripple through all 4 nibble registers.
- Add 0x7FFF + 0x0001 → sum=0x8000, overflow=1, cout=0. Then sub 0x8000 - 0x0001 → sum=0x7FFF, overflow=1, cout=1.
- Sub 0x0005 - 0x0007, cin=0 → sum=0xFFFE, cout=0 (borrow), overflow=0. Sub 0x0005 - 0x0005, cin=1 → sum=0xFFFF, cout=0.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid, while toggling start_valid/a/b → sum/flags unchanged, start_ready=0. Release → result_valid=0 next cycle, start_ready=1.
- Pulse rst 2 cycles into RUN → result_valid never rises, start_ready=1 after release. The next op 0x0001+0x0001 returns 0x0002 with no stale carry.
